// File: rtl/jellyvl_data_fifo_sync.sv
// rtl/jellyvl_data_fifo_sync.sv - single-clock valid/ready stream FIFO with occupancy and free counters
module jellyvl_data_fifo_sync #(
  parameter int                   DATA_BITS = 8,
  parameter int                   PTR_BITS  = 4,
  parameter logic [DATA_BITS-1:0] INIT_DATA = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cke,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [PTR_BITS:0]    s_free_count,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PTR_BITS:0]    m_data_count
);

  localparam int                DEPTH     = 1 << PTR_BITS;
  localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]  wptr;
  logic [PTR_BITS-1:0]  rptr;
  logic [PTR_BITS:0]    cnt;
  logic [PTR_BITS:0]    next_cnt;
  logic                 written;
  logic                 wr_en;
  logic                 rd_en;

  assign wr_en = cke && s_valid && s_ready;
  assign rd_en = cke && m_valid && m_ready;

  always_comb begin
    next_cnt = cnt;
    if (wr_en && !rd_en) begin
      next_cnt = cnt + (PTR_BITS + 1)'(1);
    end else if (!wr_en && rd_en) begin
      next_cnt = cnt - (PTR_BITS + 1)'(1);
    end
  end

  // Storage has no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      cnt     <= '0;
      written <= 1'b0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
    end else if (cke) begin
      if (wr_en) begin
        wptr    <= wptr + PTR_BITS'(1);
        written <= 1'b1;
      end
      if (rd_en) begin
        rptr <= rptr + PTR_BITS'(1);
      end
      cnt     <= next_cnt;
      s_ready <= (next_cnt != DEPTH_CNT);
      m_valid <= (next_cnt != '0);
    end
  end

  // Until the first write the RAM holds nothing meaningful, so show INIT_DATA.
  assign m_data       = written ? mem[rptr] : INIT_DATA;
  assign m_data_count = cnt;
  assign s_free_count = DEPTH_CNT - cnt;

endmodule

// File: tb/tb_jellyvl_data_fifo_sync.sv
// tb/tb_jellyvl_data_fifo_sync.sv - scoreboard bench for jellyvl_data_fifo_sync
module tb_jellyvl_data_fifo_sync;

  localparam logic [7:0] INIT = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic       cke;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [4:0] s_free_count;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic [4:0] m_data_count;

  jellyvl_data_fifo_sync #(
    .DATA_BITS(8),
    .PTR_BITS (4),
    .INIT_DATA(INIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cke         (cke),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_free_count(s_free_count),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data_count(m_data_count)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  int         model_cnt = 0;
  bit         model_ready = 1'b0;
  bit         model_valid = 1'b0;
  bit         model_written = 1'b0;
  bit         armed = 1'b0;
  bit         wr;
  bit         rd;
  logic [7:0] exp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks state left by the previous edge, then predicts the coming edge.
  always @(negedge clk) begin
    if (armed) begin
      chk("m_data_count", 32'(m_data_count), 32'(model_cnt));
      chk("s_free_count", 32'(s_free_count), 32'(16 - model_cnt));
      chk("s_ready", 32'(s_ready), 32'(model_ready));
      chk("m_valid", 32'(m_valid), 32'(model_valid));
      if (!model_written) chk("init_data", 32'(m_data), 32'(INIT));
    end
    if (reset) begin
      exp_q.delete();
      model_cnt     = 0;
      model_ready   = 1'b0;
      model_valid   = 1'b0;
      model_written = 1'b0;
      armed         = 1'b1;
    end else if (armed && cke) begin
      wr = s_valid && model_ready;
      rd = model_valid && m_ready;
      if (rd && exp_q.size() > 0) begin
        exp_data = exp_q.pop_front();
        chk("read_data", 32'(m_data), 32'(exp_data));
      end
      if (wr) begin
        exp_q.push_back(s_data);
        model_written = 1'b1;
      end
      model_cnt   = model_cnt + int'(wr) - int'(rd);
      model_ready = (model_cnt != 16);
      model_valid = (model_cnt != 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    int n;
    s_data  = d;
    s_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(s_ready && cke) && n < 100);
    if (n >= 100) chk("push_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  logic acc;

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h77;
    m_ready = 1'b0;
    tick(3);
    reset   = 1'b0;
    s_valid = 1'b0;
    tick(2);

    // Fill to full, hold a 17th word, then one read-only cycle while full.
    for (int i = 0; i < 16; i++) push_word(8'(i));
    s_data  = 8'h10;
    s_valid = 1'b1;
    tick(3);
    m_ready = 1'b1;
    tick(1);
    m_ready = 1'b0;
    tick(1);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick(20);

    // Streaming at full rate, pointers wrap several times.
    s_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_data = 8'(i + 32);
      tick(1);
    end
    s_valid = 1'b0;
    tick(4);

    // Random handshakes with random clock-enable gaps.
    acc = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!s_valid || acc) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 8'($urandom);
      end
      m_ready = 1'($urandom_range(0, 1));
      cke     = ($urandom_range(0, 9) != 0);
      @(negedge clk);
      acc = s_valid && s_ready && cke;
      @(posedge clk);
      #1;
    end
    cke     = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick(40);

    // Reset with 7 entries stored; only post-reset data may come out.
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push_word(8'(8'hC0 + i));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    for (int i = 0; i < 3; i++) push_word(8'(8'hD0 + i));
    m_ready = 1'b1;
    tick(8);

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
